// File: rtl/tcp_tx_frame_gen.sv
// tcp_tx_frame_gen: framed byte source for the SiTCP TCP TX port (A5 5A SEQ LEN payload CSUM).
// Define TXGEN_CRC8_EN to replace the XOR checksum byte with CRC-8 (poly 0x07).
module tcp_tx_frame_gen #(
    parameter int GAP_CYCLES = 8,
    parameter int LEN_W      = 16
) (
    input  logic             CLK,
    input  logic             SYS_RSTn,
    input  logic             TCP_OPEN_ACK,
    input  logic             TCP_TX_FULL,
    input  logic             START,
    input  logic             CONT_MODE,
    input  logic [LEN_W-1:0] PAY_LEN,
    output logic             TCP_TX_WR,
    output logic [7:0]       TCP_TX_DATA,
    output logic             BUSY,
    output logic [15:0]      FRAME_CNT,
    output logic [15:0]      SEQ_NUM
);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [3:0] {IDLE, HDR0, HDR1, SEQH, SEQL, LENH, LENL, PAY, CSUM, GAP} state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] len;
    logic [15:0]      idx;
    logic [7:0]       csum, byte_cur;
    logic [GW-1:0]    gap_cnt;
    logic             adv, emit, gap_end, start_frame;

    function automatic logic [7:0] csum_upd(input logic [7:0] c, input logic [7:0] b);
`ifdef TXGEN_CRC8_EN
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++)
            x = x[7] ? {x[6:0], 1'b0} ^ 8'h07 : {x[6:0], 1'b0};
        return x;
`else
        return c ^ b;
`endif
    endfunction

    assign adv     = !TCP_TX_FULL;
    assign gap_end = gap_cnt == GW'(GAP_CYCLES - 1);

    always_ff @(posedge CLK or negedge SYS_RSTn)
        if (!SYS_RSTn) state <= IDLE;
        else           state <= state_nx;

    // Connection drop dominates every other condition, including FULL.
    always_comb begin
        state_nx = state;
        if (!TCP_OPEN_ACK) state_nx = IDLE;
        else case (state)
            IDLE: state_nx = START ? HDR0 : IDLE;
            HDR0: state_nx = adv ? HDR1 : HDR0;
            HDR1: state_nx = adv ? SEQH : HDR1;
            SEQH: state_nx = adv ? SEQL : SEQH;
            SEQL: state_nx = adv ? LENH : SEQL;
            LENH: state_nx = adv ? LENL : LENH;
            LENL: state_nx = adv ? (len != '0 ? PAY : CSUM) : LENL;
            PAY:  state_nx = adv && idx == 16'(len - 1'b1) ? CSUM : PAY;
            CSUM: state_nx = adv ? (CONT_MODE ? (GAP_CYCLES == 0 ? HDR0 : GAP) : IDLE) : CSUM;
            GAP:  state_nx = gap_end ? (CONT_MODE ? HDR0 : IDLE) : GAP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        byte_cur = 8'h00;
        case (state)
            HDR0: byte_cur = 8'hA5;
            HDR1: byte_cur = 8'h5A;
            SEQH: byte_cur = SEQ_NUM[15:8];
            SEQL: byte_cur = SEQ_NUM[7:0];
            LENH: byte_cur = len[15:8];
            LENL: byte_cur = len[7:0];
            PAY:  byte_cur = SEQ_NUM[7:0] + idx[7:0];
            CSUM: byte_cur = csum;
            default: byte_cur = 8'h00;
        endcase
        emit        = TCP_OPEN_ACK && adv && state != IDLE && state != GAP;
        start_frame = state_nx == HDR0 && state != HDR0;
        BUSY        = state != IDLE;
    end

    always_ff @(posedge CLK or negedge SYS_RSTn)
        if (!SYS_RSTn) begin
            TCP_TX_WR   <= 1'b0;
            TCP_TX_DATA <= 8'h00;
            FRAME_CNT   <= 16'h0000;
            SEQ_NUM     <= 16'h0000;
            csum        <= 8'h00;
            len         <= '0;
            idx         <= 16'h0000;
            gap_cnt     <= '0;
        end else if (!TCP_OPEN_ACK) begin
            TCP_TX_WR <= 1'b0;
            FRAME_CNT <= 16'h0000;
            SEQ_NUM   <= 16'h0000;
            csum      <= 8'h00;
            idx       <= 16'h0000;
            gap_cnt   <= '0;
        end else begin
            TCP_TX_WR <= emit;
            if (emit) TCP_TX_DATA <= byte_cur;
            if (start_frame) len <= PAY_LEN;
            if (start_frame || (emit && state == CSUM)) csum <= 8'h00;
            else if (emit) csum <= csum_upd(csum, byte_cur);
            if (emit && state == CSUM) begin
                FRAME_CNT <= FRAME_CNT + 1'b1;
                SEQ_NUM   <= SEQ_NUM + 1'b1;
            end
            idx     <= state == PAY ? idx + 16'(emit) : 16'h0000;
            gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
        end
endmodule

// File: tb/tb_tcp_tx_frame_gen.sv
// tb_tcp_tx_frame_gen: scoreboard bench; expected frame bytes are queued at START and popped on each TCP_TX_WR.
module tb_tcp_tx_frame_gen;
    logic        CLK = 1'b0;
    logic        SYS_RSTn = 1'b0;
    logic        TCP_OPEN_ACK = 1'b0;
    logic        TCP_TX_FULL = 1'b0;
    logic        START = 1'b0;
    logic        CONT_MODE = 1'b0;
    logic [15:0] PAY_LEN = 16'h0000;
    logic        TCP_TX_WR;
    logic [7:0]  TCP_TX_DATA;
    logic        BUSY;
    logic [15:0] FRAME_CNT;
    logic [15:0] SEQ_NUM;

    typedef struct {
        logic [7:0] b;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_wr = 0;
    logic full_q = 1'b0;

    tcp_tx_frame_gen #(.GAP_CYCLES(8), .LEN_W(16)) dut (
        .CLK(CLK), .SYS_RSTn(SYS_RSTn), .TCP_OPEN_ACK(TCP_OPEN_ACK), .TCP_TX_FULL(TCP_TX_FULL),
        .START(START), .CONT_MODE(CONT_MODE), .PAY_LEN(PAY_LEN), .TCP_TX_WR(TCP_TX_WR),
        .TCP_TX_DATA(TCP_TX_DATA), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT), .SEQ_NUM(SEQ_NUM)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_upd(input logic [7:0] c, input logic [7:0] b);
`ifdef TXGEN_CRC8_EN
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++)
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
`else
        return c ^ b;
`endif
    endfunction

    // gap_first/gap_rest: required idle cycles before the first / later bytes, -1 = unchecked.
    task automatic push_frame(input logic [15:0] seq, input logic [15:0] len,
                              input int gap_first, input int gap_rest, input int nmax);
        logic [7:0] bytes[$];
        logic [7:0] c;
        c = 8'h00;
        bytes = {8'hA5, 8'h5A, seq[15:8], seq[7:0], len[15:8], len[7:0]};
        for (int i = 0; i < int'(len); i++) bytes.push_back(seq[7:0] + 8'(i));
        foreach (bytes[i]) c = model_upd(c, bytes[i]);
        bytes.push_back(c);
        for (int i = 0; i < bytes.size() && i < nmax; i++)
            exp_q.push_back('{b: bytes[i], gap: i == 0 ? gap_first : gap_rest});
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] len);
        PAY_LEN = len;
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!BUSY && exp_q.size() == 0) break;
        end
        chk("idle_busy", 32'(BUSY), 0);
        chk("idle_queue_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic wait_q_empty();
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            #1;
            if (exp_q.size() == 0) break;
        end
        chk("queue_drained", 32'(exp_q.size()), 0);
    endtask

    task automatic drop_link();
        TCP_OPEN_ACK = 1'b0;
        step();
        chk("drop_frame_cnt", 32'(FRAME_CNT), 0);
        chk("drop_seq", 32'(SEQ_NUM), 0);
        TCP_OPEN_ACK = 1'b1;
        step();
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        exp_t e;
        if (full_q) chk("wr_while_full", 32'(TCP_TX_WR), 0);
        full_q = TCP_TX_FULL;
        if (TCP_TX_WR) begin
            chk("wr_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("tx_byte", 32'(TCP_TX_DATA), 32'(e.b));
                if (e.gap >= 0) chk("idle_gap", 32'(cyc - last_wr - 1), 32'(e.gap));
            end
            last_wr = cyc;
        end
    end

    initial begin
        repeat (3) step();
        chk("rst_wr", 32'(TCP_TX_WR), 0);
        chk("rst_data", 32'(TCP_TX_DATA), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_frame_cnt", 32'(FRAME_CNT), 0);
        chk("rst_seq", 32'(SEQ_NUM), 0);
        SYS_RSTn = 1'b1;
        step();
        pulse_start(16'd4);
        chk("start_ignored_closed", 32'(BUSY), 0);
        TCP_OPEN_ACK = 1'b1;
        repeat (2) step();
        chk("no_autostart", 32'(BUSY), 0);

        // Basic 4-byte payload frame, 11 back-to-back pulses.
        push_frame(16'h0000, 16'd4, -1, 0, 1000);
        pulse_start(16'd4);
        chk("busy_after_start", 32'(BUSY), 1);
        pulse_start(16'd9);
        wait_idle();
        chk("s1_frame_cnt", 32'(FRAME_CNT), 1);
        chk("s1_seq", 32'(SEQ_NUM), 1);

        // Empty payload.
        drop_link();
        push_frame(16'h0000, 16'd0, -1, 0, 1000);
        pulse_start(16'd0);
        wait_idle();
        chk("s2_frame_cnt", 32'(FRAME_CNT), 1);

        // FULL held for 5 cycles in the middle of the payload.
        push_frame(16'h0001, 16'd16, -1, -1, 1000);
        pulse_start(16'd16);
        repeat (9) step();
        TCP_TX_FULL = 1'b1;
        repeat (5) step();
        chk("full_busy", 32'(BUSY), 1);
        TCP_TX_FULL = 1'b0;
        wait_idle();
        chk("s3_seq", 32'(SEQ_NUM), 2);

        // Continuous mode, three frames separated by 8 idle cycles.
        drop_link();
        CONT_MODE = 1'b1;
        push_frame(16'h0000, 16'd2, -1, 0, 1000);
        push_frame(16'h0001, 16'd2, 8, 0, 1000);
        push_frame(16'h0002, 16'd2, 8, 0, 1000);
        pulse_start(16'd2);
        wait_q_empty();
        CONT_MODE = 1'b0;
        wait_idle();
        chk("s4_frame_cnt", 32'(FRAME_CNT), 3);
        chk("s4_seq", 32'(SEQ_NUM), 3);

        // Connection drop right after payload byte 3.
        push_frame(16'h0003, 16'd16, -1, 0, 10);
        pulse_start(16'd16);
        wait_q_empty();
        TCP_OPEN_ACK = 1'b0;
        @(negedge CLK);
        #1;
        chk("drop_wr", 32'(TCP_TX_WR), 0);
        chk("drop_busy", 32'(BUSY), 0);
        chk("drop_frame_cnt_mid", 32'(FRAME_CNT), 0);
        chk("drop_seq_mid", 32'(SEQ_NUM), 0);
        repeat (3) step();
        TCP_OPEN_ACK = 1'b1;
        step();
        push_frame(16'h0000, 16'd3, -1, 0, 1000);
        pulse_start(16'd3);
        wait_idle();
        chk("s5_frame_cnt", 32'(FRAME_CNT), 1);
        chk("s5_seq", 32'(SEQ_NUM), 1);

        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
